// File: rtl/md_if.sv
// Request/response bundle between the execute stage and the M-extension sequencer.
// An operation transfers on a rising edge where valid_i & ready_o & ~flush_i; ready_o is a
// pure function of sequencer state and never depends on valid_i, and result_valid_o is a one-cycle pulse.
interface md_if #(
   parameter int XLEN = 32
);
   logic            valid_i;
   logic [2:0]      funct3_i;
   logic [XLEN-1:0] op_a_i;
   logic [XLEN-1:0] op_b_i;
   logic            flush_i;
   logic            ready_o;
   logic            busy_o;
   logic            result_valid_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output valid_i, funct3_i, op_a_i, op_b_i, flush_i,
      input  ready_o, busy_o, result_valid_o, result_o
   );

   modport slave (
      input  valid_i, funct3_i, op_a_i, op_b_i, flush_i,
      output ready_o, busy_o, result_valid_o, result_o
   );
endinterface

// File: rtl/md_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up and early completion of divide corner cases.
module md_sequencer #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   md_if.slave        bus,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [4:0]          cnt_q;
   logic [2:0]          op_q;
   logic [XLEN-1:0]     mag_a_q, mag_b_q;
   logic                neg_q, neg_r;
   logic [2*XLEN-1:0]   acc_q;
   logic [XLEN-1:0]     result_q, result_d;
   logic                result_load;

   logic                accept;
   logic                a_signed, b_signed, sign_a, sign_b;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic                special;
   logic [XLEN-1:0]     special_res;

   assign accept = bus.valid_i & (state_q == IDLE) & ~bus.flush_i;

   // Bit 2 splits multiply from divide; divides are signed when bit 0 is clear.
   assign a_signed = bus.funct3_i[2] ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
   assign b_signed = bus.funct3_i[2] ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
   assign sign_a   = a_signed & bus.op_a_i[XLEN-1];
   assign sign_b   = b_signed & bus.op_b_i[XLEN-1];
   assign mag_a    = sign_a ? (~bus.op_a_i + 1'b1) : bus.op_a_i;
   assign mag_b    = sign_b ? (~bus.op_b_i + 1'b1) : bus.op_b_i;

   always_comb begin
      special     = 1'b0;
      special_res = '0;
      if (bus.funct3_i[2]) begin
         if (bus.op_b_i == '0) begin
            special     = 1'b1;
            special_res = bus.funct3_i[1] ? bus.op_a_i : '1;
         end else if (~bus.funct3_i[0] && bus.op_a_i == {1'b1, {(XLEN-1){1'b0}}}
                      && bus.op_b_i == '1) begin
            special     = 1'b1;
            special_res = bus.funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
         end
      end
   end

   // One multiply step: conditional add into the high half, then shift {carry, acc} right.
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

   // One divide step: shift {rem, quot} left, trial-subtract the divisor from the widened remainder.
   logic [XLEN:0]     div_rem_sh;
   logic [XLEN+1:0]   div_trial;
   logic [2*XLEN-1:0] div_next;
   assign div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
   assign div_trial  = {1'b0, div_rem_sh} - {2'b00, mag_b_q};
   assign div_next   = div_trial[XLEN+1] ? {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                         : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot, rem, fix_res;
   assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
   assign quot     = acc_q[XLEN-1:0];
   assign rem      = acc_q[2*XLEN-1:XLEN];

   always_comb begin
      fix_res = '0;
      if (!op_q[2])
         fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      else if (op_q[1])
         fix_res = neg_r ? (~rem + 1'b1) : rem;
      else
         fix_res = neg_q ? (~quot + 1'b1) : quot;
   end

   always_comb begin
      state_d     = state_q;
      result_load = 1'b0;
      result_d    = result_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (special) begin
                  state_d     = DONE;
                  result_load = 1'b1;
                  result_d    = special_res;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (bus.flush_i)
               state_d = IDLE;
            else if (cnt_q == 5'd31)
               state_d = FIXUP;
         end
         FIXUP: begin
            if (bus.flush_i) begin
               state_d = IDLE;
            end else begin
               state_d     = DONE;
               result_load = 1'b1;
               result_d    = fix_res;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (result_load)
            result_q <= result_d;
         if (accept) begin
            op_q    <= bus.funct3_i;
            mag_a_q <= mag_a;
            mag_b_q <= mag_b;
            neg_q   <= sign_a ^ sign_b;
            neg_r   <= sign_a;
            cnt_q   <= '0;
            // The low half seeds the multiplier (multiply) or the dividend (divide).
            acc_q   <= {{XLEN{1'b0}}, bus.funct3_i[2] ? mag_a : mag_b};
         end else if (state_q == CALC && !bus.flush_i) begin
            cnt_q <= cnt_q + 5'd1;
            acc_q <= op_q[2] ? div_next : mul_next;
         end
      end
   end

   assign bus.ready_o        = (state_q == IDLE);
   assign bus.busy_o         = (state_q == CALC) || (state_q == FIXUP);
   assign bus.result_valid_o = (state_q == DONE);
   assign bus.result_o       = result_q;
   assign dbg_state          = state_q;

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Iterative M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) execution unit with its own control FSM. It sits beside the ALU in the execute stage. It accepts one operation per valid/ready handshake and stalls the core through `ready_o`/`busy_o`. It returns a single-cycle `result_valid_o` pulse. Multiplication uses radix-2 shift-add and division uses restoring division, both on operand magnitudes with sign fix-up at the end. Divide corner cases defined by RV32M complete early.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_i`  in  1  operation request; accepted on an edge where `valid_i & ready_o & ~flush_i`.
- `funct3_i`  in  3  operation encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a_i`  in  XLEN  rs1 value (multiplicand / dividend).
- `op_b_i`  in  XLEN  rs2 value (multiplier / divisor).
- `flush_i`  in  1  abort the in-flight operation (pipeline flush / trap).
- `ready_o`  out  1  high only in IDLE.
- `busy_o`  out  1  high in CALC or FIXUP.
- `result_valid_o`  out  1  high only in DONE (exactly one cycle per completed operation).
- `result_o`  out  XLEN  registered result; holds its value until the next result load.

## Operation
- FSM states and transitions:
  - IDLE: on accept → CALC, or → DONE for a special case.
  - CALC: 32 iterations, counter 0..31; after iteration 31 → FIXUP.
  - FIXUP → DONE.
  - DONE → IDLE.
- Accept captures `funct3`, operand magnitudes, and sign flags `neg_q`/`neg_r` into internal registers. Inputs are don't-care after the accepting edge.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV/REM: both signed.
- A magnitude of a signed operand is its two's-complement negation when bit 31 = 1. 0x80000000 has magnitude 0x80000000 as an unsigned value.
- Multiply, one CALC step:
  - If multiplier bit 0 = 1, add the 32-bit multiplicand into product[63:32] with a 33-bit carry.
  - Shift the {carry, product} register right by 1.
  - After 32 steps the register holds the 64-bit unsigned product.
- Multiply FIXUP:
  - Negate the 64-bit product if the operand signs differ.
  - MUL returns bits [31:0]; the other three multiply ops return [63:32].
- Divide, one CALC step:
  - Shift {rem, quot} left by 1.
  - Trial subtract = rem − |b| at 33 bits.
  - If the trial subtract is non-negative: rem = difference and quot[0] = 1.
- Divide FIXUP:
  - DIV: quotient negated if sign(a) ≠ sign(b).
  - REM: remainder negated if sign(a) = 1.
- Special cases, detected in IDLE at accept; the result loads directly and the FSM goes straight to DONE:
  - b = 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - DIV with a = 0x80000000 and b = 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0x00000000.
  - Multiplies never take the special-case path.
- Flush:
  - In CALC or FIXUP: next state IDLE; `result_o` unchanged; no `result_valid_o`.
  - In IDLE: suppresses accept.
  - In DONE: no extra effect; the pulse already shown still counts as delivered.
- Reset: state IDLE, counter 0, all internal registers 0. Outputs: `ready_o` = 1, `busy_o` = 0, `result_valid_o` = 0, `result_o` = 0.

## Timing
- Accept on edge E0 with a normal operation:
  - CALC during E1..E32 (32 iterations).
  - E32 → FIXUP.
  - E33 → DONE: `result_valid_o` = 1 and `result_o` is valid in the cycle after E33.
  - E34 → IDLE.
- Special case accepted on E0: DONE after E0, result visible in the following cycle, IDLE after E1.
- `ready_o` is low from after the accepting edge until IDLE is re-entered. There is no back-to-back accept from DONE.
- `result_o` updates on the edge entering DONE and stays stable through IDLE. It is not cleared by flush.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous). The first accept is possible on the first edge after `rst` deasserts.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) accepted at E0 → `result_valid_o` in the cycle after E33, `result_o` = 0xFFFFFFEB; MULH of the same operands → 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2; all at 33-edge latency.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5, pulse one edge after accept; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, also early.
- Flush asserted 10 edges after accepting DIV 100 / 7 → IDLE next edge, `ready_o` = 1, no `result_valid_o`, `result_o` keeps the previous value. `valid_i` and `flush_i` high together in IDLE → not accepted.
- `rst` pulsed during CALC → `ready_o` = 1, `busy_o` = 0, `result_o` = 0 immediately. A following MUL 3 × 4 → 12 with normal latency.
